mic1_regbank: RTL and testbench
===============================

Name: mic1_regbank

Overview:
- MIC-1 datapath register bank sitting around the ALU.
- Upstream side: drives the A-bus (H) and the B-bus (one register per b_sel) into the ALU.
- Downstream side: takes the ALU result through the shifter onto the C-bus, writes the registers selected by c_sel, and latches the N/Z flags.
- Also owns the MAR/MDR/PC/MBR memory interface with the standard two-cycle read return.

Parameters:
- DATA_W, 32, datapath width.
- PC_INIT, 32'h0, PC reset value.
- SP_INIT, 32'h0, SP reset value.
- LV_INIT, 32'h0, LV reset value.
- CPP_INIT, 32'h0, CPP reset value.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- alu_out  in  DATA_W  ALU result.
- alu_n  in  1  ALU N flag.
- alu_z  in  1  ALU Z flag.
- shift  in  2  bit1 = SLL8, bit0 = SRA1.
- c_sel  in  9  C-bus write mask, {H,OPC,TOS,CPP,LV,SP,PC,MDR,MAR}.
- b_sel  in  4  B-bus source select.
- mem_rd  in  1  start data read at MAR.
- mem_wr  in  1  start data write of MDR to MAR.
- mem_fetch  in  1  start byte fetch at PC.
- mem_rdata  in  DATA_W  data-read return.
- mem_fdata  in  8  fetch return.
- a_bus  out  DATA_W  = H.
- b_bus  out  DATA_W  selected B source.
- c_bus  out  DATA_W  shifter output.
- n_flag  out  1  latched N.
- z_flag  out  1  latched Z.
- mar_o  out  DATA_W  MAR (word address).
- mdr_o  out  DATA_W  MDR (write data).
- pc_o  out  DATA_W  PC (byte address).
- rd_req  out  1  registered mem_rd.
- wr_req  out  1  registered mem_wr.
- fetch_req  out  1  registered mem_fetch.

Behaviour:
- Reset (rst_n=0 at posedge):
  - H, OPC, TOS, MAR, MDR, MBR = 0.
  - PC/SP/LV/CPP = their *_INIT parameters.
  - n_flag = 0, z_flag = 0.
  - rd_req, wr_req, fetch_req = 0; both pending-return stages cleared.
  - Reset mid-read/fetch: the return is dropped; MDR/MBR hold reset values.
- Shifter (combinational):
  - c_bus = alu_out for shift 00.
  - alu_out << 8, zero fill, for shift 10.
  - Arithmetic >> 1, sign replicated, for shift 01.
  - shift 11 is illegal: pass-through (alu_out) and simulation assertion.
- Combinational reads:
  - a_bus = H.
  - b_bus sources: 0 MDR, 1 PC, 2 sign-extended MBR, 3 zero-extended MBR, 4 SP, 5 LV, 6 CPP, 7 TOS, 8 OPC, 9-15 = 0.
  - Same-cycle writes are not visible until the next cycle; no bypass.
- C-bus writeback: each register whose c_sel bit is 1 loads c_bus at posedge. Multiple bits may be set together. MBR is not C-writable.
- Flags: n_flag <= alu_n and z_flag <= alu_z every cycle (pre-shift ALU flags). Latency 1.
- Memory request timing:
  - Requests are registered: rd_req/wr_req/fetch_req assert in cycle k+1 for a request in cycle k.
  - In that cycle, MAR/PC already include any cycle-k C-bus write, so the address used is the post-write value.
  - wr_req samples mdr_o in the same cycle.
- Read return:
  - mem_rdata / mem_fdata are valid during the cycle rd_req / fetch_req is high.
  - MDR / MBR load them at the end of that cycle, so the value is readable on the B-bus in cycle k+2.
- Conflict rule: if c_sel writes MDR in the same cycle a read return lands, the C-bus value wins and the returned data is discarded.
- mem_rd and mem_wr together are legal; both requests issue.
- Back-to-back: consecutive rd or fetch each cycle is legal and pipelines fully, one return per cycle.

Decomposition:
- Shared package mic1_pkg holds:
  - b_sel codes (B_MDR … B_OPC).
  - c_sel bit indices (C_MAR=0 … C_H=8).
  - shift codes (SH_NONE, SH_SRA1, SH_SLL8).
  - DATA_W default.
- One sub-module: mic1_shifter (combinational shift/pass).

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with SP_INIT=32'h100 -> SP=32'h100 via b_sel=4; n_flag=z_flag=0; rd_req=0.
- Shifter: alu_out=32'h8000_00F1 with shift 01 -> c_bus=32'hC000_0078; with shift 10 -> 32'h0000_F100. Set c_sel H bit -> a_bus=32'h0000_F100 next cycle.
- Multi-write and flags: alu_out=0, alu_z=1, c_sel=9'h1F0 -> H, OPC, TOS, CPP, LV all read 0 next cycle; z_flag=1 for exactly the following cycle.
- Read latency: cycle k writes MAR=5 with mem_rd=1 -> rd_req=1 and mar_o=5 in k+1. mem_rdata=32'hDEADBEEF in k+1 -> b_bus (sel 0) = 32'hDEADBEEF in k+2.
- Fetch/MBR: mem_fetch=1, mem_fdata=8'hF3 on return -> b_sel 2 gives 32'hFFFF_FFF3; b_sel 3 gives 32'h0000_00F3.
- Conflict and reset: MDR C-write of 32'h1234 in the return cycle -> MDR=32'h1234. Separately, assert rst_n=0 in the rd_req cycle -> MDR=0 afterwards.

Source files
------------

// File: rtl/mic1_pkg.sv
// mic1_pkg
// Shared definitions for the MIC-1 register bank slice:
//   - DATA_W_DEF : default datapath width
//   - b_sel_e    : B-bus source select codes
//   - C_*        : bit positions inside the 9-bit C-bus write mask
//   - shift_e    : shifter control codes
package mic1_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [3:0] {
    B_MDR  = 4'd0,
    B_PC   = 4'd1,
    B_MBR  = 4'd2,
    B_MBRU = 4'd3,
    B_SP   = 4'd4,
    B_LV   = 4'd5,
    B_CPP  = 4'd6,
    B_TOS  = 4'd7,
    B_OPC  = 4'd8
  } b_sel_e;

  localparam int C_MAR = 0;
  localparam int C_MDR = 1;
  localparam int C_PC  = 2;
  localparam int C_SP  = 3;
  localparam int C_LV  = 4;
  localparam int C_CPP = 5;
  localparam int C_TOS = 6;
  localparam int C_OPC = 7;
  localparam int C_H   = 8;

  typedef enum logic [1:0] {
    SH_NONE    = 2'b00,
    SH_SRA1    = 2'b01,
    SH_SLL8    = 2'b10,
    SH_ILLEGAL = 2'b11
  } shift_e;

endpackage

// File: rtl/mic1_regbank_if.sv
// mic1_regbank_if
// Groups the ALU-side and memory-side signals of the register bank.
//   slave  modport : used by mic1_regbank (takes ALU result, controls, memory returns;
//                    drives A/B/C buses, flags and memory requests)
//   master modport : used by whatever sequences the datapath (control store / bench)
interface mic1_regbank_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] alu_out;
  logic              alu_n;
  logic              alu_z;
  logic [1:0]        shift;
  logic [8:0]        c_sel;
  logic [3:0]        b_sel;
  logic              mem_rd;
  logic              mem_wr;
  logic              mem_fetch;
  logic [DATA_W-1:0] mem_rdata;
  logic [7:0]        mem_fdata;

  logic [DATA_W-1:0] a_bus;
  logic [DATA_W-1:0] b_bus;
  logic [DATA_W-1:0] c_bus;
  logic              n_flag;
  logic              z_flag;
  logic [DATA_W-1:0] mar_o;
  logic [DATA_W-1:0] mdr_o;
  logic [DATA_W-1:0] pc_o;
  logic              rd_req;
  logic              wr_req;
  logic              fetch_req;

  modport slave (
    input  alu_out, alu_n, alu_z, shift, c_sel, b_sel,
           mem_rd, mem_wr, mem_fetch, mem_rdata, mem_fdata,
    output a_bus, b_bus, c_bus, n_flag, z_flag,
           mar_o, mdr_o, pc_o, rd_req, wr_req, fetch_req
  );

  modport master (
    output alu_out, alu_n, alu_z, shift, c_sel, b_sel,
           mem_rd, mem_wr, mem_fetch, mem_rdata, mem_fdata,
    input  a_bus, b_bus, c_bus, n_flag, z_flag,
           mar_o, mdr_o, pc_o, rd_req, wr_req, fetch_req
  );
endinterface

// File: rtl/mic1_shifter.sv
// mic1_shifter
// Combinational MIC-1 shifter between the ALU and the C-bus.
//   alu_out : ALU result
//   shift   : bit1 = SLL8 (zero fill), bit0 = SRA1 (sign replicate)
//   c_bus   : shifted result; the illegal code 11 passes alu_out through
module mic1_shifter
  import mic1_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] alu_out,
  input  logic [1:0]        shift,
  output logic [DATA_W-1:0] c_bus
);

  always_comb begin
    c_bus = alu_out;
    case (shift)
      SH_SLL8: c_bus = alu_out << 8;
      SH_SRA1: c_bus = DATA_W'($signed(alu_out) >>> 1);
      default: c_bus = alu_out;
    endcase
  end

endmodule

// File: rtl/mic1_regbank.sv
// mic1_regbank
// MIC-1 datapath register bank around the ALU.
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : mic1_regbank_if slave port carrying
//                ALU side    - alu_out/alu_n/alu_z/shift in, a_bus/b_bus/c_bus/n_flag/z_flag out
//                control     - c_sel write mask, b_sel B-bus source
//                memory side - mem_rd/mem_wr/mem_fetch requests, mem_rdata/mem_fdata returns,
//                              mar_o/mdr_o/pc_o and registered rd_req/wr_req/fetch_req
// Reads return while the registered request is high and land in MDR/MBR at the
// end of that cycle, giving the usual two-cycle MIC-1 read latency.
module mic1_regbank
  import mic1_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [DATA_W-1:0] PC_INIT  = '0,
  parameter logic [DATA_W-1:0] SP_INIT  = '0,
  parameter logic [DATA_W-1:0] LV_INIT  = '0,
  parameter logic [DATA_W-1:0] CPP_INIT = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  mic1_regbank_if.slave   bus
);

  logic [DATA_W-1:0] h_q,   h_d;
  logic [DATA_W-1:0] opc_q, opc_d;
  logic [DATA_W-1:0] tos_q, tos_d;
  logic [DATA_W-1:0] cpp_q, cpp_d;
  logic [DATA_W-1:0] lv_q,  lv_d;
  logic [DATA_W-1:0] sp_q,  sp_d;
  logic [DATA_W-1:0] pc_q,  pc_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [DATA_W-1:0] mar_q, mar_d;
  logic [7:0]        mbr_q, mbr_d;
  logic              n_q, n_d;
  logic              z_q, z_d;
  logic              rd_req_q, rd_req_d;
  logic              wr_req_q, wr_req_d;
  logic              fetch_req_q, fetch_req_d;

  logic [DATA_W-1:0] c_bus_w;

  mic1_shifter #(.DATA_W(DATA_W)) u_shifter (
    .alu_out (bus.alu_out),
    .shift   (bus.shift),
    .c_bus   (c_bus_w)
  );

  assign bus.c_bus = c_bus_w;

  // Next-state: C-bus writes per mask bit; a read return fills MDR only when
  // the C-bus is not writing MDR in the same cycle. Requests are simply delayed
  // one cycle so the address they present already includes any C-bus write.
  always_comb begin
    h_d         = h_q;
    opc_d       = opc_q;
    tos_d       = tos_q;
    cpp_d       = cpp_q;
    lv_d        = lv_q;
    sp_d        = sp_q;
    pc_d        = pc_q;
    mdr_d       = mdr_q;
    mar_d       = mar_q;
    mbr_d       = mbr_q;
    n_d         = bus.alu_n;
    z_d         = bus.alu_z;
    rd_req_d    = bus.mem_rd;
    wr_req_d    = bus.mem_wr;
    fetch_req_d = bus.mem_fetch;

    if (bus.c_sel[C_H])   h_d   = c_bus_w;
    if (bus.c_sel[C_OPC]) opc_d = c_bus_w;
    if (bus.c_sel[C_TOS]) tos_d = c_bus_w;
    if (bus.c_sel[C_CPP]) cpp_d = c_bus_w;
    if (bus.c_sel[C_LV])  lv_d  = c_bus_w;
    if (bus.c_sel[C_SP])  sp_d  = c_bus_w;
    if (bus.c_sel[C_PC])  pc_d  = c_bus_w;
    if (bus.c_sel[C_MAR]) mar_d = c_bus_w;

    if (bus.c_sel[C_MDR]) begin
      mdr_d = c_bus_w;
    end else if (rd_req_q) begin
      mdr_d = bus.mem_rdata;
    end

    if (fetch_req_q) mbr_d = bus.mem_fdata;
  end

  // State register; reset also drops any return that is in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_q         <= '0;
      opc_q       <= '0;
      tos_q       <= '0;
      cpp_q       <= CPP_INIT;
      lv_q        <= LV_INIT;
      sp_q        <= SP_INIT;
      pc_q        <= PC_INIT;
      mdr_q       <= '0;
      mar_q       <= '0;
      mbr_q       <= '0;
      n_q         <= 1'b0;
      z_q         <= 1'b0;
      rd_req_q    <= 1'b0;
      wr_req_q    <= 1'b0;
      fetch_req_q <= 1'b0;
    end else begin
      h_q         <= h_d;
      opc_q       <= opc_d;
      tos_q       <= tos_d;
      cpp_q       <= cpp_d;
      lv_q        <= lv_d;
      sp_q        <= sp_d;
      pc_q        <= pc_d;
      mdr_q       <= mdr_d;
      mar_q       <= mar_d;
      mbr_q       <= mbr_d;
      n_q         <= n_d;
      z_q         <= z_d;
      rd_req_q    <= rd_req_d;
      wr_req_q    <= wr_req_d;
      fetch_req_q <= fetch_req_d;
    end
  end

  // B-bus source mux; MBR is offered both sign- and zero-extended.
  always_comb begin
    bus.b_bus = '0;
    case (bus.b_sel)
      B_MDR:   bus.b_bus = mdr_q;
      B_PC:    bus.b_bus = pc_q;
      B_MBR:   bus.b_bus = {{(DATA_W-8){mbr_q[7]}}, mbr_q};
      B_MBRU:  bus.b_bus = {{(DATA_W-8){1'b0}}, mbr_q};
      B_SP:    bus.b_bus = sp_q;
      B_LV:    bus.b_bus = lv_q;
      B_CPP:   bus.b_bus = cpp_q;
      B_TOS:   bus.b_bus = tos_q;
      B_OPC:   bus.b_bus = opc_q;
      default: bus.b_bus = '0;
    endcase
  end

  assign bus.a_bus     = h_q;
  assign bus.n_flag    = n_q;
  assign bus.z_flag    = z_q;
  assign bus.mar_o     = mar_q;
  assign bus.mdr_o     = mdr_q;
  assign bus.pc_o      = pc_q;
  assign bus.rd_req    = rd_req_q;
  assign bus.wr_req    = wr_req_q;
  assign bus.fetch_req = fetch_req_q;

  // Shift code 11 has no defined meaning; it only passes the ALU result through.
  a_shift_legal : assert property (@(posedge clk) disable iff (!rst_n)
    bus.shift != SH_ILLEGAL)
    else $error("mic1_regbank: illegal shift code 11");

endmodule

// File: tb/tb_mic1_regbank.sv
// tb_mic1_regbank
// Self-checking bench for mic1_regbank: directed scenarios followed by random
// cycles, all compared against a register-file reference model kept here.
module tb_mic1_regbank;
  import mic1_pkg::*;

  localparam int          W    = 32;
  localparam logic [31:0] PCI  = 32'h0000_0040;
  localparam logic [31:0] SPI  = 32'h0000_0100;
  localparam logic [31:0] LVI  = 32'h0000_0200;
  localparam logic [31:0] CPPI = 32'h0000_0300;

  // Model register indices follow the C-bus mask bit order.
  localparam int M_MAR = 0, M_MDR = 1, M_PC = 2, M_SP = 3, M_LV = 4,
                 M_CPP = 5, M_TOS = 6, M_OPC = 7, M_H = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mic1_regbank_if #(.DATA_W(W)) bus ();

  mic1_regbank #(
    .DATA_W(W), .PC_INIT(PCI), .SP_INIT(SPI), .LV_INIT(LVI), .CPP_INIT(CPPI)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] m_reg [9];
  logic [7:0]  m_mbr;
  logic        m_n, m_z, m_rd, m_wr, m_fe;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] shiftRef(input logic [31:0] a, input logic [1:0] sh);
    logic [31:0] r;
    r = a;
    if (sh == 2'b10) r = a * 32'd256;
    else if (sh == 2'b01) r = (a / 32'd2) + (a[31] ? 32'h8000_0000 : 32'h0);
    return r;
  endfunction

  function automatic logic [31:0] bRef(input logic [3:0] sel);
    logic [31:0] r;
    r = 32'h0;
    case (sel)
      4'd0: r = m_reg[M_MDR];
      4'd1: r = m_reg[M_PC];
      4'd2: r = m_mbr[7] ? (32'hFFFF_FF00 | 32'(m_mbr)) : 32'(m_mbr);
      4'd3: r = 32'(m_mbr);
      4'd4: r = m_reg[M_SP];
      4'd5: r = m_reg[M_LV];
      4'd6: r = m_reg[M_CPP];
      4'd7: r = m_reg[M_TOS];
      4'd8: r = m_reg[M_OPC];
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  task automatic applyStimulus(input logic rstn, input logic [31:0] alu, input logic n,
                               input logic z, input logic [1:0] sh, input logic [8:0] cs,
                               input logic [3:0] bs, input logic rd, input logic wr,
                               input logic fe, input logic [31:0] rdata, input logic [7:0] fdata);
    rst_n         = rstn;
    bus.alu_out   = alu;
    bus.alu_n     = n;
    bus.alu_z     = z;
    bus.shift     = sh;
    bus.c_sel     = cs;
    bus.b_sel     = bs;
    bus.mem_rd    = rd;
    bus.mem_wr    = wr;
    bus.mem_fetch = fe;
    bus.mem_rdata = rdata;
    bus.mem_fdata = fdata;
  endtask

  task automatic idle();
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 2'b00, 9'h0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h0);
  endtask

  task automatic checkAll();
    checkOutput("a_bus",     bus.a_bus,            m_reg[M_H]);
    checkOutput("b_bus",     bus.b_bus,            bRef(bus.b_sel));
    checkOutput("c_bus",     bus.c_bus,            shiftRef(bus.alu_out, bus.shift));
    checkOutput("n_flag",    32'(bus.n_flag),      32'(m_n));
    checkOutput("z_flag",    32'(bus.z_flag),      32'(m_z));
    checkOutput("mar_o",     bus.mar_o,            m_reg[M_MAR]);
    checkOutput("mdr_o",     bus.mdr_o,            m_reg[M_MDR]);
    checkOutput("pc_o",      bus.pc_o,             m_reg[M_PC]);
    checkOutput("rd_req",    32'(bus.rd_req),      32'(m_rd));
    checkOutput("wr_req",    32'(bus.wr_req),      32'(m_wr));
    checkOutput("fetch_req", 32'(bus.fetch_req),   32'(m_fe));
  endtask

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic modelEdge();
    logic [31:0] c;
    if (!rst_n) begin
      foreach (m_reg[i]) m_reg[i] = 32'h0;
      m_reg[M_PC]  = PCI;
      m_reg[M_SP]  = SPI;
      m_reg[M_LV]  = LVI;
      m_reg[M_CPP] = CPPI;
      m_mbr = 8'h0;
      m_n = 1'b0; m_z = 1'b0; m_rd = 1'b0; m_wr = 1'b0; m_fe = 1'b0;
    end else begin
      c = shiftRef(bus.alu_out, bus.shift);
      if (m_rd) m_reg[M_MDR] = bus.mem_rdata;
      for (int i = 0; i < 9; i++) if (bus.c_sel[i]) m_reg[i] = c;
      if (m_fe) m_mbr = bus.mem_fdata;
      m_n  = bus.alu_n;
      m_z  = bus.alu_z;
      m_rd = bus.mem_rd;
      m_wr = bus.mem_wr;
      m_fe = bus.mem_fetch;
    end
  endtask

  // Inputs are driven at negedge, outputs sampled 1 time unit later.
  task automatic advance(input bit chk);
    #1;
    if (chk) checkAll();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
  endtask

  initial begin
    foreach (m_reg[i]) m_reg[i] = 32'h0;
    m_mbr = 8'h0;
    m_n = 1'b0; m_z = 1'b0; m_rd = 1'b0; m_wr = 1'b0; m_fe = 1'b0;

    // Reset held for two cycles
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    advance(1'b0);
    advance(1'b1);
    idle();
    bus.b_sel = 4'd4;
    #1;
    checkOutput("reset_sp", bus.b_bus, 32'h0000_0100);
    checkOutput("reset_z",  32'(bus.z_flag), 32'h0);
    checkOutput("reset_rd", 32'(bus.rd_req), 32'h0);
    advance(1'b1);

    // Shifter
    idle();
    bus.alu_out = 32'h8000_00F1;
    bus.shift   = 2'b01;
    #1 checkOutput("sra1", bus.c_bus, 32'hC000_0078);
    bus.shift = 2'b10;
    bus.c_sel = 9'h100;
    #1 checkOutput("sll8", bus.c_bus, 32'h0000_F100);
    advance(1'b1);
    idle();
    #1 checkOutput("h_write", bus.a_bus, 32'h0000_F100);
    advance(1'b1);

    // Multi-write and Z flag for exactly one cycle
    idle();
    bus.alu_z = 1'b1;
    bus.c_sel = 9'h1F0;
    advance(1'b1);
    idle();
    bus.b_sel = 4'd5;
    #1 checkOutput("multi_lv", bus.b_bus, 32'h0);
    checkOutput("z_set", 32'(bus.z_flag), 32'h1);
    checkOutput("multi_h", bus.a_bus, 32'h0);
    advance(1'b1);
    idle();
    bus.b_sel = 4'd6;
    #1 checkOutput("multi_cpp", bus.b_bus, 32'h0);
    checkOutput("z_clear", 32'(bus.z_flag), 32'h0);
    advance(1'b1);

    // Read latency
    idle();
    bus.alu_out = 32'd5;
    bus.c_sel   = 9'h001;
    bus.mem_rd  = 1'b1;
    advance(1'b1);
    idle();
    bus.mem_rdata = 32'hDEAD_BEEF;
    #1 checkOutput("rd_req_k1", 32'(bus.rd_req), 32'h1);
    checkOutput("mar_k1", bus.mar_o, 32'd5);
    advance(1'b1);
    idle();
    #1 checkOutput("rd_data_k2", bus.b_bus, 32'hDEAD_BEEF);
    advance(1'b1);

    // Fetch into MBR
    idle();
    bus.mem_fetch = 1'b1;
    advance(1'b1);
    idle();
    bus.mem_fdata = 8'hF3;
    #1 checkOutput("fetch_req_k1", 32'(bus.fetch_req), 32'h1);
    advance(1'b1);
    idle();
    bus.b_sel = 4'd2;
    #1 checkOutput("mbr_sext", bus.b_bus, 32'hFFFF_FFF3);
    bus.b_sel = 4'd3;
    #1 checkOutput("mbr_zext", bus.b_bus, 32'h0000_00F3);
    advance(1'b1);

    // C-bus write of MDR beats the read return
    idle();
    bus.mem_rd = 1'b1;
    advance(1'b1);
    idle();
    bus.mem_rdata = 32'hCAFE_F00D;
    bus.alu_out   = 32'h0000_1234;
    bus.c_sel     = 9'h002;
    advance(1'b1);
    idle();
    #1 checkOutput("conflict_mdr", bus.b_bus, 32'h0000_1234);
    advance(1'b1);

    // Reset during the return cycle drops the data
    idle();
    bus.mem_rd = 1'b1;
    advance(1'b1);
    idle();
    rst_n = 1'b0;
    bus.mem_rdata = 32'h5555_AAAA;
    advance(1'b1);
    idle();
    #1 checkOutput("reset_drop", bus.b_bus, 32'h0);
    advance(1'b1);

    // Random operation against the model
    for (int cyc = 0; cyc < 400; cyc++) begin
      applyStimulus(($urandom_range(31, 0) != 0), $urandom(), 1'($urandom()), 1'($urandom()),
                    2'($urandom_range(2, 0)), 9'($urandom()), 4'($urandom()),
                    1'($urandom()), 1'($urandom()), 1'($urandom()),
                    $urandom(), 8'($urandom()));
      advance(1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running want finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
